// File: rtl/axi_rd_mux_pkg.sv
// Shared types and AXI encodings for the N-channel AXI3 read multiplexer.
// Imported by the interface, the arbiter and the top level.
package axi_rd_mux_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP = 2'b10;

  localparam logic [3:0] AXI_CACHE_ALL  = 4'b1111;
  localparam logic [3:0] AXI_CACHE_NONE = 4'b0000;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic        wrap;
    logic        cached;
  } rd_ch_req_t;

  typedef enum logic [0:0] {
    StIdle,
    StIssue
  } ar_state_e;

  function automatic logic [1:0] burst_of(input logic wrap);
    return wrap ? AXI_BURST_WRAP : AXI_BURST_INCR;
  endfunction

  function automatic logic [3:0] cache_of(input logic cached);
    return cached ? AXI_CACHE_ALL : AXI_CACHE_NONE;
  endfunction

endpackage

// File: rtl/axi_rd_mux_if.sv
// AXI3 read address and read data channels.
// The master modport is the multiplexer side; slave is the interconnect side.
interface axi_rd_mux_if #(
  parameter int unsigned ID_W = 4
);

  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic [1:0]      arlock;
  logic [3:0]      arcache;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;

  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi_rd_mux_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping modulo N. Returns a one-hot grant and its index.
module axi_rd_mux_rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o
);

  localparam int unsigned IdxW = $clog2(N);

  logic            found;
  logic [IdxW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IdxW'((32'(ptr_i) + i) % N);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/axi_rd_mux.sv
// N-channel AXI3 read multiplexer: round-robin AR issue with ARID = channel,
// one burst in flight per channel, R beats routed back to their source by RID.
module axi_rd_mux
  import axi_rd_mux_pkg::*;
#(
  parameter int unsigned N_CH            = 4,
  parameter int unsigned ID_W            = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N_CH-1:0]       i_req_valid,
  output logic [N_CH-1:0]       o_req_ready,
  input  logic [N_CH-1:0][31:0] i_req_addr,
  input  logic [N_CH-1:0][7:0]  i_req_len,
  input  logic [N_CH-1:0][2:0]  i_req_size,
  input  logic [N_CH-1:0]       i_req_wrap,
  input  logic [N_CH-1:0]       i_req_cached,
  output logic [N_CH-1:0]       o_resp_valid,
  output logic [31:0]           o_resp_data,
  output logic                  o_resp_last,
  output logic                  o_resp_err,
  output logic                  o_proto_err,
  axi_rd_mux_if.master          axi
);

  localparam int unsigned IdxW = $clog2(N_CH);
  localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);

  ar_state_e       state_q;
  logic [IdxW-1:0] grant_q, rr_ptr_q;
  logic            arvalid_q;
  logic [ID_W-1:0] arid_q;
  logic [31:0]     araddr_q;
  logic [7:0]      arlen_q;
  logic [2:0]      arsize_q;
  logic [1:0]      arburst_q;
  logic [3:0]      arcache_q;

  logic [N_CH-1:0] busy_q, busy_d;
  logic [OutW-1:0] outstanding_q, outstanding_d;

  logic            room;
  logic [N_CH-1:0] elig, arb_gnt, rid_onehot;
  logic [IdxW-1:0] arb_idx, rid_idx, next_ptr;
  rd_ch_req_t      sel_req;
  logic            ar_hs, beat_fire, rid_in_range, beat_ok, last_ok;

  assign axi.arvalid = arvalid_q;
  assign axi.arid    = arid_q;
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = arlen_q;
  assign axi.arsize  = arsize_q;
  assign axi.arburst = arburst_q;
  assign axi.arcache = arcache_q;
  assign axi.arlock  = 2'b00;
  assign axi.arprot  = 3'b000;
  // No backpressure: beats are always accepted outside reset.
  assign axi.rready  = ~i_rst;

  assign room = 32'(outstanding_q) < MAX_OUTSTANDING;
  assign elig = i_req_valid & ~busy_q & {N_CH{room}};

  axi_rd_mux_rr_arbiter #(
    .N (N_CH)
  ) u_arb (
    .req_i (elig),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  always_comb begin
    sel_req.addr   = i_req_addr[arb_idx];
    sel_req.len    = i_req_len[arb_idx];
    sel_req.size   = i_req_size[arb_idx];
    sel_req.wrap   = i_req_wrap[arb_idx];
    sel_req.cached = i_req_cached[arb_idx];
  end

  assign ar_hs    = arvalid_q && axi.arready;
  assign next_ptr = (grant_q == IdxW'(N_CH - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    o_req_ready = '0;
    if (ar_hs) o_req_ready[grant_q] = 1'b1;
  end

  // AR issue FSM; payload is frozen while waiting for arready.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      arvalid_q <= 1'b0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
      arcache_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (|arb_gnt) begin
            grant_q   <= arb_idx;
            arid_q    <= ID_W'(arb_idx);
            araddr_q  <= sel_req.addr;
            arlen_q   <= sel_req.len;
            arsize_q  <= sel_req.size;
            arburst_q <= burst_of(sel_req.wrap);
            arcache_q <= cache_of(sel_req.cached);
            arvalid_q <= 1'b1;
            state_q   <= StIssue;
          end
        end
        StIssue: begin
          if (axi.arready) begin
            arvalid_q <= 1'b0;
            rr_ptr_q  <= next_ptr;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign beat_fire    = axi.rvalid && axi.rready;
  assign rid_in_range = 32'(axi.rid) < N_CH;
  assign rid_idx      = axi.rid[IdxW-1:0];
  assign beat_ok      = beat_fire && rid_in_range && busy_q[rid_idx];
  assign last_ok      = beat_ok && axi.rlast;

  always_comb begin
    rid_onehot          = '0;
    rid_onehot[rid_idx] = 1'b1;
  end

  // A retiring channel is never the one being granted, so both edits are independent.
  always_comb begin
    busy_d = busy_q;
    if (last_ok) busy_d[rid_idx] = 1'b0;
    if (ar_hs)   busy_d[grant_q] = 1'b1;
    outstanding_d = outstanding_q;
    if (ar_hs && !last_ok)      outstanding_d = outstanding_q + OutW'(1);
    else if (!ar_hs && last_ok) outstanding_d = outstanding_q - OutW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy_q        <= '0;
      outstanding_q <= '0;
    end else begin
      busy_q        <= busy_d;
      outstanding_q <= outstanding_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_resp_valid <= '0;
      o_resp_data  <= '0;
      o_resp_last  <= 1'b0;
      o_resp_err   <= 1'b0;
      o_proto_err  <= 1'b0;
    end else begin
      o_resp_valid <= '0;
      o_resp_last  <= 1'b0;
      o_resp_err   <= 1'b0;
      if (beat_ok) begin
        o_resp_valid <= rid_onehot;
        o_resp_data  <= axi.rdata;
        o_resp_last  <= axi.rlast;
        o_resp_err   <= (axi.rresp != 2'b00);
      end
      if (beat_fire && !beat_ok) o_proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_rd_mux.sv
// Directed bench for axi_rd_mux: AR issue/hold, round-robin, burst routing,
// interleaving, error flags and the outstanding cap (second instance, cap 2).
module tb_axi_rd_mux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]       req_valid, req_ready, req2_valid, req2_ready;
  logic [3:0][31:0] req_addr;
  logic [3:0][7:0]  req_len;
  logic [3:0][2:0]  req_size;
  logic [3:0]       req_wrap, req_cached;
  logic [3:0]       resp_valid, resp2_valid;
  logic [31:0]      resp_data, resp2_data;
  logic             resp_last, resp_err, proto_err;
  logic             resp2_last, resp2_err, proto2_err;

  int n_vec  = 0;
  int n_miss = 0;

  logic [3:0]  il_id   [4];
  logic [31:0] il_data [4];
  logic [1:0]  il_resp [4];
  logic        il_last [4];
  logic        il_err  [4];
  logic [3:0]  seen, pend;

  axi_rd_mux_if #(.ID_W(4)) axi ();
  axi_rd_mux_if #(.ID_W(4)) axi2 ();

  axi_rd_mux #(.N_CH(4), .ID_W(4), .MAX_OUTSTANDING(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_addr(req_addr), .i_req_len(req_len), .i_req_size(req_size),
    .i_req_wrap(req_wrap), .i_req_cached(req_cached), .o_resp_valid(resp_valid),
    .o_resp_data(resp_data), .o_resp_last(resp_last), .o_resp_err(resp_err),
    .o_proto_err(proto_err), .axi(axi)
  );

  axi_rd_mux #(.N_CH(4), .ID_W(4), .MAX_OUTSTANDING(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req2_valid), .o_req_ready(req2_ready),
    .i_req_addr(req_addr), .i_req_len(req_len), .i_req_size(req_size),
    .i_req_wrap(req_wrap), .i_req_cached(req_cached), .o_resp_valid(resp2_valid),
    .o_resp_data(resp2_data), .o_resp_last(resp2_last), .o_resp_err(resp2_err),
    .o_proto_err(proto2_err), .axi(axi2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int ch, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic wrap, input logic cached);
    req_addr[ch]   = addr;
    req_len[ch]    = len;
    req_size[ch]   = size;
    req_wrap[ch]   = wrap;
    req_cached[ch] = cached;
  endtask

  task automatic beat(input logic [3:0] id, input logic [31:0] data, input logic [1:0] resp,
                      input logic last);
    axi.rvalid = 1'b1;
    axi.rid    = id;
    axi.rdata  = data;
    axi.rresp  = resp;
    axi.rlast  = last;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    req_valid = '0;  req2_valid = '0;
    req_addr  = '0;  req_len = '0;  req_size = '0;  req_wrap = '0;  req_cached = '0;
    axi.arready  = 1'b0; axi.rvalid  = 1'b0; axi.rid  = '0; axi.rdata  = '0;
    axi.rresp    = '0;   axi.rlast   = 1'b0;
    axi2.arready = 1'b0; axi2.rvalid = 1'b0; axi2.rid = '0; axi2.rdata = '0;
    axi2.rresp   = '0;   axi2.rlast  = 1'b0;
    il_id   = '{4'd1, 4'd3, 4'd1, 4'd3};
    il_data = '{32'hA1A1_0001, 32'hB3B3_0001, 32'hA1A1_0002, 32'hB3B3_0002};
    il_resp = '{2'b00, 2'b10, 2'b00, 2'b00};
    il_last = '{1'b0, 1'b0, 1'b1, 1'b1};
    il_err  = '{1'b0, 1'b1, 1'b0, 1'b0};
    set_req(0, 32'h0000_1000, 8'd0,  3'd2, 1'b0, 1'b0);
    set_req(1, 32'h0000_2000, 8'd1,  3'd2, 1'b0, 1'b0);
    set_req(2, 32'h1FC0_0040, 8'd15, 3'd2, 1'b1, 1'b1);
    set_req(3, 32'h8000_3000, 8'd1,  3'd2, 1'b0, 1'b1);

    // Reset values
    repeat (3) tick();
    check("rst_arvalid", axi.arvalid, 1'b0);
    check("rst_ar_payload", {axi.arid, axi.araddr, axi.arlen, axi.arsize, axi.arburst,
                             axi.arcache, axi.arlock, axi.arprot}, 64'd0);
    check("rst_rready", axi.rready, 1'b0);
    check("rst_req_ready", req_ready, 4'b0000);
    check("rst_resp", {resp_valid, resp_last, resp_err, proto_err}, 7'd0);
    rst = 1'b0;
    #1;
    check("rready_after_rst", axi.rready, 1'b1);

    // Basic issue on ch2 with arready held low, ch0 arriving meanwhile
    req_valid = 4'b0100;
    tick();
    check("ar_ch2_valid", axi.arvalid, 1'b1);
    check("ar_ch2_fields", {axi.arid, axi.araddr, axi.arlen, axi.arsize},
          {4'd2, 32'h1FC0_0040, 8'd15, 3'd2});
    check("ar_ch2_burst", axi.arburst, 2'b10);
    check("ar_ch2_cache", axi.arcache, 4'b1111);
    check("ar_ch2_no_ready", req_ready, 4'b0000);
    req_valid = 4'b0101;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("ar_hold", {axi.arvalid, axi.arid, axi.araddr, axi.arlen},
            {1'b1, 4'd2, 32'h1FC0_0040, 8'd15});
    end
    axi.arready = 1'b1;
    #1;
    check("req_ready_ch2", req_ready, 4'b0100);
    tick();
    req_valid = 4'b0001;
    check("ar_drop", axi.arvalid, 1'b0);
    check("req_ready_gap", req_ready, 4'b0000);
    tick();
    check("ar_ch0_fields", {axi.arid, axi.araddr, axi.arlen, axi.arburst, axi.arcache},
          {4'd0, 32'h0000_1000, 8'd0, 2'b01, 4'b0000});
    check("req_ready_ch0", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0000;

    // Sixteen-beat burst on rid 2
    for (int i = 0; i < 16; i++) begin
      beat(4'd2, 32'hD000_0000 + i, 2'b00, i == 15);
      tick();
      check("burst_valid", resp_valid, 4'b0100);
      check("burst_data", resp_data, 32'hD000_0000 + i);
      check("burst_last", resp_last, i == 15);
    end
    axi.rvalid = 1'b0;
    tick();
    check("burst_idle", {resp_valid, resp_last}, 5'd0);

    // Issue ch1 and ch3, then interleave their beats
    req_valid = 4'b1010;
    tick();
    check("ar_ch1", {axi.arvalid, axi.arid}, {1'b1, 4'd1});
    check("req_ready_ch1", req_ready, 4'b0010);
    tick();
    req_valid = 4'b1000;
    tick();
    check("ar_ch3", {axi.arid, axi.arcache}, {4'd3, 4'b1111});
    check("req_ready_ch3", req_ready, 4'b1000);
    tick();
    req_valid = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      beat(il_id[i], il_data[i], il_resp[i], il_last[i]);
      tick();
      check("il_valid", resp_valid, (il_id[i] == 4'd1) ? 4'b0010 : 4'b1000);
      check("il_data", resp_data, il_data[i]);
      check("il_err", resp_err, il_err[i]);
      check("il_last", resp_last, il_last[i]);
    end
    beat(4'd0, 32'hC0DE_0000, 2'b00, 1'b1);
    tick();
    axi.rvalid = 1'b0;
    check("ch0_beat", {resp_valid, resp_last, resp_err}, {4'b0001, 1'b1, 1'b0});

    // Round-robin order with all four requesting
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_order", {axi.arvalid, axi.arid}, {1'b1, 4'(k)});
      tick();
      req_valid[k] = 1'b0;
    end
    req_valid[0] = 1'b1;
    tick();
    check("rr_busy_block", axi.arvalid, 1'b0);
    beat(4'd0, 32'h0000_0000, 2'b00, 1'b1);
    tick();
    axi.rvalid = 1'b0;
    check("rr_resp_ch0", resp_valid, 4'b0001);
    check("rr_not_same_cycle", axi.arvalid, 1'b0);
    tick();
    check("rr_regrant_ch0", {axi.arvalid, axi.arid}, {1'b1, 4'd0});
    beat(4'd1, 32'h0000_0011, 2'b00, 1'b1);  // retires alongside the AR handshake
    tick();
    req_valid = 4'b0000;
    check("rr_resp_ch1", resp_valid, 4'b0010);
    beat(4'd2, 32'h0000_0022, 2'b00, 1'b1);
    tick();
    check("rr_resp_ch2", resp_valid, 4'b0100);
    beat(4'd3, 32'h0000_0033, 2'b00, 1'b1);
    tick();
    check("rr_resp_ch3", resp_valid, 4'b1000);
    beat(4'd0, 32'h0000_0044, 2'b00, 1'b1);
    tick();
    axi.rvalid = 1'b0;
    check("rr_resp_ch0b", resp_valid, 4'b0001);

    // Counter must be back to zero: four fresh requests all issue
    req_valid = 4'b1111;
    seen = '0;
    pend = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      req_valid &= ~pend;
      pend = req_ready;
      seen |= req_ready;
    end
    check("refill_all_four", seen, 4'b1111);

    // Protocol errors
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("proto_pre", proto_err, 1'b0);
    beat(4'd2, 32'h0000_0BAD, 2'b00, 1'b1);
    tick();
    axi.rvalid = 1'b0;
    check("proto_nonbusy_drop", resp_valid, 4'b0000);
    check("proto_nonbusy", proto_err, 1'b1);
    tick();
    check("proto_sticky", proto_err, 1'b1);
    rst = 1'b1;
    tick();
    check("rst_proto_clr", proto_err, 1'b0);
    check("rst_arvalid_again", axi.arvalid, 1'b0);
    rst = 1'b0;
    beat(4'd5, 32'h0000_0555, 2'b00, 1'b0);
    tick();
    axi.rvalid = 1'b0;
    check("proto_rid5_drop", resp_valid, 4'b0000);
    check("proto_rid5", proto_err, 1'b1);

    // Outstanding cap of 2 on the second instance
    axi2.arready = 1'b1;
    req2_valid = 4'b0111;
    seen = '0;
    pend = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      req2_valid &= ~pend;
      pend = req2_ready;
      seen |= req2_ready;
    end
    check("cap_two_issued", seen, 4'b0011);
    check("cap_third_held", axi2.arvalid, 1'b0);
    axi2.rvalid = 1'b1;
    axi2.rid    = 4'd0;
    axi2.rdata  = 32'h0000_CAFE;
    axi2.rlast  = 1'b1;
    tick();
    axi2.rvalid = 1'b0;
    check("cap_t1_no_ar", axi2.arvalid, 1'b0);
    check("cap_resp", {resp2_valid, resp2_data, resp2_last, resp2_err},
          {4'b0001, 32'h0000_CAFE, 1'b1, 1'b0});
    tick();
    check("cap_t2_ar_ch2", {axi2.arvalid, axi2.arid}, {1'b1, 4'd2});
    check("cap_no_proto", proto2_err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
